sysid_boot_checker: RTL and testbench

//  Avalon-MM read master that sits directly downstream of the system-ID slave.
//  On a start request it reads sysid word 0 (system ID) and word 1 (build timestamp).
//  It compares both against compile-time expectations and reports pass/fail.

---
 rtl/sysid_boot_checker_if.sv | 21 ++
 rtl/sysid_boot_checker.sv | 173 +++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read channel between the boot checker (master) and the sysid slave.
//   sysid_address  : word select, 0 = system ID, 1 = build timestamp
//   sysid_read     : one-cycle read strobe per word
//   sysid_readdata : 32-bit read data returned by the slave
interface sysid_boot_checker_if;
    logic        sysid_address;
    logic        sysid_read;
    logic [31:0] sysid_readdata;

    modport master (
        output sysid_address,
        output sysid_read,
        input  sysid_readdata
    );

    modport slave (
        input  sysid_address,
        input  sysid_read,
        output sysid_readdata
    );
endinterface

// File: rtl/sysid_boot_checker.sv
// Boot-time system ID checker. Reads sysid word 0 (ID) and optionally word 1
// (build timestamp), compares both against compile-time expectations and
// holds a pass/fail verdict that gates CPU release.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   start             : request a check (honoured only in IDLE/DONE)
//   bus               : Avalon-MM read master toward the sysid slave
//   busy / done       : check in progress / verdict valid
//   pass, *_mismatch  : verdict flags, valid while done=1
//   id_value/ts_value : captured words
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1353410341,
    parameter int unsigned READ_LATENCY       = 0,
    parameter bit          CHECK_TIMESTAMP    = 1'b1,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    sysid_boot_checker_if.master   bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   id_mismatch,
    output logic                   ts_mismatch,
    output logic [31:0]            id_value,
    output logic [31:0]            ts_value
);
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ID, S_WAIT_ID, S_RD_TS, S_WAIT_TS, S_CHECK, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                auto_q, auto_d;
    logic                addr_q, addr_d;
    logic                rd_q, rd_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                id_mis_q, id_mis_d;
    logic                ts_mis_q, ts_mis_d;
    logic [DATA_W-1:0]   id_val_q, id_val_d;
    logic [DATA_W-1:0]   ts_val_q, ts_val_d;

    logic                last_wait_c;
    logic                id_mis_c;
    logic                ts_mis_c;
    state_e              after_id_c;

    // Last WAIT cycle: the slave's data is valid now.
    assign last_wait_c = ((32'(cnt_q) + 32'd1) >= 32'(READ_LATENCY));
    assign id_mis_c    = (id_val_q != EXPECTED_ID);
    assign ts_mis_c    = CHECK_TIMESTAMP && (ts_val_q != EXPECTED_TIMESTAMP);
    assign after_id_c  = CHECK_TIMESTAMP ? S_RD_TS : S_CHECK;

    // State register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            auto_q   <= AUTO_START;
            addr_q   <= 1'b0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            id_mis_q <= 1'b0;
            ts_mis_q <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            auto_q   <= auto_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            id_mis_q <= id_mis_d;
            ts_mis_q <= ts_mis_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    // Next-state logic, capture and compare.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        auto_d   = auto_q;
        pass_d   = pass_q;
        id_mis_d = id_mis_q;
        ts_mis_d = ts_mis_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start || auto_q) begin
                    state_d  = S_RD_ID;
                    auto_d   = 1'b0;
                    pass_d   = 1'b0;
                    id_mis_d = 1'b0;
                    ts_mis_d = 1'b0;
                end
            end
            S_RD_ID: begin
                cnt_d = '0;
                if (READ_LATENCY == 0) begin
                    id_val_d = bus.sysid_readdata;
                    state_d  = after_id_c;
                end else begin
                    state_d = S_WAIT_ID;
                end
            end
            S_WAIT_ID: begin
                if (last_wait_c) begin
                    id_val_d = bus.sysid_readdata;
                    cnt_d    = '0;
                    state_d  = after_id_c;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            S_RD_TS: begin
                cnt_d = '0;
                if (READ_LATENCY == 0) begin
                    ts_val_d = bus.sysid_readdata;
                    state_d  = S_CHECK;
                end else begin
                    state_d = S_WAIT_TS;
                end
            end
            S_WAIT_TS: begin
                if (last_wait_c) begin
                    ts_val_d = bus.sysid_readdata;
                    cnt_d    = '0;
                    state_d  = S_CHECK;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            S_CHECK: begin
                id_mis_d = id_mis_c;
                ts_mis_d = ts_mis_c;
                pass_d   = ~(id_mis_c | ts_mis_c);
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus and status outputs follow the state being entered.
        rd_d   = (state_d == S_RD_ID) || (state_d == S_RD_TS);
        addr_d = (state_d == S_RD_TS) || (state_d == S_WAIT_TS);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    assign bus.sysid_address = addr_q;
    assign bus.sysid_read    = rd_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign pass              = pass_q;
    assign id_mismatch       = id_mis_q;
    assign ts_mismatch       = ts_mis_q;
    assign id_value          = id_val_q;
    assign ts_value          = ts_val_q;
endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker. Three instances:
//   0: L=0, timestamp checked, auto-start
//   1: L=2, timestamp checked, auto-start
//   2: L=1, timestamp skipped, no auto-start
module tb_sysid_boot_checker;
    localparam logic [31:0] TSV     = 32'd1353410341;
    localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

    typedef struct {
        int          rd0;
        int          rd1;
        int          dcyc;
        bit          ts_en;
        bit          pass;
        bit          idm;
        bit          tsm;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_v [3];
    logic [31:0] slv_id  [3];
    logic [31:0] slv_ts  [3];
    logic        rd_v    [3];
    logic        addr_v  [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        pass_v  [3];
    logic        idm_v   [3];
    logic        tsm_v   [3];
    logic [31:0] idv_v   [3];
    logic [31:0] tsv_v   [3];

    exp_t exp_q [3][$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rd_cnt [3];
    logic prev_done [3];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L   = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
        localparam bit          TSE = (g != 2);
        localparam bit          AUT = (g != 2);

        sysid_boot_checker_if bus_i ();
        logic [3:0] hist;
        logic       valid;

        sysid_boot_checker #(
            .READ_LATENCY    (L),
            .CHECK_TIMESTAMP (TSE),
            .AUTO_START      (AUT)
        ) dut (
            .clock       (clock),
            .reset       (reset),
            .start       (start_v[g]),
            .bus         (bus_i),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .pass        (pass_v[g]),
            .id_mismatch (idm_v[g]),
            .ts_mismatch (tsm_v[g]),
            .id_value    (idv_v[g]),
            .ts_value    (tsv_v[g])
        );

        // Slave model: data valid only L cycles after the strobe, garbage otherwise.
        always @(posedge clock or posedge reset) begin
            if (reset) hist <= '0;
            else       hist <= {hist[2:0], bus_i.sysid_read};
        end
        if (L == 0) begin : g_l0
            assign valid = bus_i.sysid_read;
        end else begin : g_ln
            assign valid = hist[L-1];
        end
        assign bus_i.sysid_readdata = valid ? (bus_i.sysid_address ? slv_ts[g] : slv_id[g]) : GARBAGE;
        assign rd_v[g]   = bus_i.sysid_read;
        assign addr_v[g] = bus_i.sysid_address;
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h exp=%h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input int k, input int l, input bit ts_en, input bit p,
                        input bit idm, input bit tsm, input logic [31:0] idv, input logic [31:0] tsv);
        exp_t e;
        e.rd0   = k;
        e.rd1   = k + 1 + l;
        e.dcyc  = ts_en ? (k + 3 + 2 * l) : (k + 2 + l);
        e.ts_en = ts_en;
        e.pass  = p;
        e.idm   = idm;
        e.tsm   = tsm;
        e.idv   = idv;
        e.tsv   = tsv;
        exp_q[i].push_back(e);
    endtask

    // Monitor: checks read pulses and verdicts against queued expectations.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) rd_cnt[i] = 0;
            chk("busy_and_done", i, 32'(busy_v[i] & done_v[i]), 32'd0);
            if (rd_v[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk("unexp_read", i, 32'd1, 32'd0);
                end else if (rd_cnt[i] == 0) begin
                    chk("rd0_cyc", i, 32'(cyc), 32'(exp_q[i][0].rd0));
                    chk("rd0_addr", i, 32'(addr_v[i]), 32'd0);
                end else if (rd_cnt[i] == 1 && exp_q[i][0].ts_en) begin
                    chk("rd1_cyc", i, 32'(cyc), 32'(exp_q[i][0].rd1));
                    chk("rd1_addr", i, 32'(addr_v[i]), 32'd1);
                end else begin
                    chk("extra_read", i, 32'(rd_cnt[i]), 32'd0);
                end
                rd_cnt[i]++;
            end
            if (done_v[i] && !prev_done[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk("unexp_done", i, 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    chk("done_cyc", i, 32'(cyc), 32'(e.dcyc));
                    chk("n_reads", i, 32'(rd_cnt[i]), e.ts_en ? 32'd2 : 32'd1);
                    chk("pass", i, 32'(pass_v[i]), 32'(e.pass));
                    chk("id_mismatch", i, 32'(idm_v[i]), 32'(e.idm));
                    chk("ts_mismatch", i, 32'(tsm_v[i]), 32'(e.tsm));
                    chk("id_value", i, idv_v[i], e.idv);
                    chk("ts_value", i, tsv_v[i], e.tsv);
                end
                rd_cnt[i] = 0;
            end
            prev_done[i] = done_v[i];
        end
    end

    task automatic drain();
        int n;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            n = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
            if (n == 0) break;
        end
        repeat (2) @(negedge clock);
        n = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        chk("drain_timeout", 0, 32'(n), 32'd0);
    endtask

    task automatic run(input int i, input int l, input bit ts_en, input bit p, input bit idm,
                       input bit tsm, input logic [31:0] idv, input logic [31:0] tsv);
        @(negedge clock);
        start_v[i] = 1'b1;
        push(i, cyc + 1, l, ts_en, p, idm, tsm, idv, tsv);
        @(negedge clock);
        start_v[i] = 1'b0;
    endtask

    task automatic chk_zero(input string nm, input int i);
        chk({nm, "_busy"}, i, 32'(busy_v[i]), 32'd0);
        chk({nm, "_done"}, i, 32'(done_v[i]), 32'd0);
        chk({nm, "_pass"}, i, 32'(pass_v[i]), 32'd0);
        chk({nm, "_read"}, i, 32'(rd_v[i]), 32'd0);
        chk({nm, "_addr"}, i, 32'(addr_v[i]), 32'd0);
        chk({nm, "_idv"}, i, idv_v[i], 32'd0);
        chk({nm, "_tsv"}, i, tsv_v[i], 32'd0);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i]   = 1'b0;
            slv_id[i]    = 32'd0;
            slv_ts[i]    = TSV;
            rd_cnt[i]    = 0;
            prev_done[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) chk_zero("rst", i);

        // Auto-start after reset release on instances 0 and 1.
        reset = 1'b0;
        k = cyc + 1;
        push(0, k, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, TSV);
        push(1, k, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, TSV);
        drain();

        // Wrong system ID.
        slv_id[0] = 32'h0000_0005;
        run(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0005, TSV);
        drain();

        // Restart from DONE after a failing run: flags clear on entry to RD_ID.
        slv_id[0] = 32'd0;
        @(negedge clock);
        start_v[0] = 1'b1;
        push(0, cyc + 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, TSV);
        @(negedge clock);
        start_v[0] = 1'b0;
        chk("clr_done", 0, 32'(done_v[0]), 32'd0);
        chk("clr_idm", 0, 32'(idm_v[0]), 32'd0);
        chk("clr_busy", 0, 32'(busy_v[0]), 32'd1);
        drain();

        // Timestamp skipped: only word 0 read, ts_value stays 0.
        slv_ts[2] = 32'hDEAD_BEEF;
        run(2, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();
        slv_id[2] = 32'h1234_5678;
        run(2, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'd0);
        drain();

        // Latency 2 with garbage outside capture cycles; then timestamp mismatch.
        run(1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, TSV);
        drain();
        slv_ts[1] = 32'd1;
        run(1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1);
        drain();

        // Start held through busy, then reset during WAIT_TS.
        slv_ts[1] = TSV;
        slv_id[1] = 32'h0000_0005;
        @(negedge clock);
        start_v[1] = 1'b1;
        push(1, cyc + 1, 2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0005, TSV);
        repeat (5) @(negedge clock);
        chk("pre_rst_addr", 1, 32'(addr_v[1]), 32'd1);
        chk("pre_rst_idv", 1, idv_v[1], 32'h0000_0005);
        reset = 1'b1;
        start_v[1] = 1'b0;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        #1;
        chk_zero("abort", 1);
        chk_zero("abort", 0);
        repeat (2) @(negedge clock);
        slv_id[1] = 32'd0;
        reset = 1'b0;
        k = cyc + 1;
        push(0, k, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, TSV);
        push(1, k, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, TSV);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
